// File: rtl/hack_pkg.sv
// Shared sizing constants for the Hack memory hierarchy so the CPU top level
// and every memory bank pull word and address widths from one place.
package hack_pkg;

  localparam int WORD_W       = 16;
  localparam int RAM8_ADDR_W  = 3;
  localparam int RAM64_ADDR_W = 6;

endpackage

// File: rtl/register_n.sv
// WIDTH-bit storage register with load enable and asynchronous active-low clear.
module register_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when load is high; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ram_n.sv
// Word-addressed RAM built from load-enabled registers. A one-hot decode of
// the shared address steers the write enable; a read mux selects the word.
// READ_REG=1 adds a read register so out reflects the word as it stood
// before the same edge's write (read-old-data on read-during-write).
import hack_pkg::*;

module ram_n #(
  parameter int WIDTH    = WORD_W,
  parameter int ADDR_W   = RAM8_ADDR_W,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] sel;
  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] rd_word;

  // Decoder plus storage: exactly one word sees load, all others hold.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    assign sel[g] = load && (address == ADDR_W'(g));

    register_n #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sel[g]),
      .d     (in),
      .q     (words[g])
    );
  end

  // Read mux: select the addressed word; depends only on stored state and address.
  always_comb begin
    rd_word = words[address];
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [WIDTH-1:0] out_p1;
    logic             vld_p1;

    // Read stage: register the pre-write word and flag valid from the first live edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_p1 <= '0;
        vld_p1 <= 1'b0;
      end else begin
        out_p1 <= rd_word;
        vld_p1 <= 1'b1;
      end
    end

    assign out       = out_p1;
    assign out_valid = vld_p1;
  end else begin : g_rd_comb
    assign out       = rd_word;
    assign out_valid = rst_n;
  end

endmodule

// File: tb/tb_ram_n.sv
// Randomised scoreboard bench for ram_n: combinational and registered-read
// 8x16 instances share stimulus, plus a 2x1 instance for the extreme sizes.
module tb_ram_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out_c, out_r;
  logic        vld_c, vld_r;

  logic [0:0]  a1;
  logic [0:0]  in1;
  logic        load1;
  logic [0:0]  out1;
  logic        vld1;

  ram_n #(.WIDTH(16), .ADDR_W(3), .READ_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .address(address), .in(in), .load(load),
    .out(out_c), .out_valid(vld_c)
  );

  ram_n #(.WIDTH(16), .ADDR_W(3), .READ_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .address(address), .in(in), .load(load),
    .out(out_r), .out_valid(vld_r)
  );

  ram_n #(.WIDTH(1), .ADDR_W(1), .READ_REG(0)) u_bit (
    .clk(clk), .rst_n(rst_n), .address(a1), .in(in1), .load(load1),
    .out(out1), .out_valid(vld1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain word arrays updated at each clock edge.
  logic [15:0] mem  [8];
  logic        mem1 [2];

  // Expected responses awaiting the monitors.
  logic [15:0] q_pre  [$];
  logic [15:0] q_post [$];
  logic [15:0] q_reg  [$];
  logic        q1_pre [$];
  logic        q1_post[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor before the edge: combinational reads show the pre-write contents.
  always begin
    @(negedge clk);
    #3;
    if (q_pre.size() > 0) begin
      chk("comb_pre", out_c, q_pre.pop_front());
      chk("comb_valid", vld_c, 1);
    end
    if (q1_pre.size() > 0) begin
      chk("bit_pre", out1, q1_pre.pop_front());
      chk("bit_valid", vld1, 1);
    end
  end

  // Monitor after the edge: combinational shows new data, registered shows old.
  always begin
    @(posedge clk);
    #1;
    if (q_post.size() > 0) chk("comb_post", out_c, q_post.pop_front());
    if (q_reg.size() > 0) begin
      chk("reg_valid", vld_r, 1);
      chk("reg_out", out_r, q_reg.pop_front());
    end
    if (q1_post.size() > 0) chk("bit_post", out1, q1_post.pop_front());
  end

  task automatic step(input logic [2:0] a, input logic [15:0] d, input logic l);
    @(negedge clk);
    address = a;
    in      = d;
    load    = l;
    q_pre.push_back(mem[a]);
    q_post.push_back(l ? d : mem[a]);
    q_reg.push_back(mem[a]);
    if (l) mem[a] = d;
  endtask

  task automatic step1(input logic a, input logic d, input logic l);
    @(negedge clk);
    a1    = a;
    in1   = d;
    load1 = l;
    q1_pre.push_back(mem1[a]);
    q1_post.push_back(l ? d : mem1[a]);
    if (l) mem1[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem1[0] = 1'b0;
    mem1[1] = 1'b0;
  endtask

  // Mid-cycle reset pulse with load possibly still high; reset must win.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_comb_out", out_c, 0);
    chk("rst_comb_valid", vld_c, 0);
    chk("rst_reg_out", out_r, 0);
    chk("rst_reg_valid", vld_r, 0);
    chk("rst_bit_out", out1, 0);
    clear_model();
    @(negedge clk);
    load  = 1'b0;
    load1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    address = '0;
    in      = '0;
    load    = 1'b0;
    a1      = '0;
    in1     = '0;
    load1   = 1'b0;
    clear_model();
    #2;
    rst_n = 1'b0;
    #1;
    chk("init_comb_out", out_c, 0);
    chk("init_reg_out", out_r, 0);
    chk("init_reg_valid", vld_r, 0);
    chk("init_comb_valid", vld_c, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clears a written word without an edge.
    step(3'd5, 16'hBEEF, 1'b1);
    pulse_reset();
    step(3'd5, 16'h0000, 1'b0);

    // Fill and readback.
    for (int i = 0; i < 8; i++) step(3'(i), 16'(i * 16'h1111), 1'b1);
    for (int i = 0; i < 8; i++) step(3'(i), 16'h0000, 1'b0);

    // Hold with load low.
    step(3'd2, 16'h1234, 1'b1);
    repeat (3) step(3'd2, 16'hFFFF, 1'b0);
    step(3'd2, 16'h0000, 1'b0);

    // Read-during-write to the same address.
    step(3'd3, 16'h00AA, 1'b1);
    step(3'd3, 16'h0055, 1'b1);
    step(3'd3, 16'h0000, 1'b0);
    step(3'd3, 16'h0000, 1'b0);

    // Randomised traffic with a reset partway through.
    for (int n = 0; n < 300; n++) begin
      if (n == 150) pulse_reset();
      step(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Extreme sizes: one bit wide, two words deep.
    step1(1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, 1'b1);
    step1(1'b1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++)
      step1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    chk("drain", q_pre.size() + q_post.size() + q_reg.size() + q1_pre.size() + q1_post.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
